// File: rtl/rx_mac_ring_writer_if.sv
// MAC RX AXI-Stream bundle between the MAC (master) and the ring writer (slave).
interface rx_mac_ring_writer_if;
    // A beat transfers on a rising clk edge where s_axis_tvalid && s_axis_tready.
    // The master holds its payload stable while valid is high and ready is low.
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready
    );
endinterface

// File: rtl/rx_mac_ring_writer.sv
// Writes MAC RX frames into a 64-bit ring: payload at header+2, then a two-word
// header (length/src/dst, timestamp) committed only for good frames.
module rx_mac_ring_writer #(
    parameter int AW          = 10,
    parameter int MAX_FILL    = 921,
    parameter int MAX_BEATS   = 190,
    parameter int TS_SRC      = 1,
    parameter int NS_STEP     = 6,
    parameter int CYC_PER_SEC = 156250000
) (
    input  logic                 clk,
    input  logic                 reset,
    rx_mac_ring_writer_if.slave  s_axis,
    output logic [AW-1:0]        wr_addr,
    output logic [63:0]          wr_data,
    output logic                 wr_en,
    output logic [AW-1:0]        commited_wr_address,
    input  logic                 commited_rd_address_change,
    input  logic [AW-1:0]        commited_rd_address,
    output logic [31:0]          dropped_full_cnt,
    output logic [31:0]          dropped_err_cnt,
    output logic [31:0]          dropped_long_cnt,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_HDR0 = 3'd2,
        ST_HDR1 = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    localparam logic [AW:0] FILL_LIM  = (AW+1)'(MAX_FILL);
    localparam logic [15:0] BEATS_LIM = 16'(MAX_BEATS);
    localparam logic [31:0] CYC_LAST  = 32'(CYC_PER_SEC - 1);
    localparam logic [31:0] NS_INC    = 32'(NS_STEP);

    state_t        state_q, state_nxt;
    logic          tready_q, tready_nxt;
    logic [AW-1:0] aux_ptr, rd_ptr, fill_q, hdr_addr;
    logic          chg_s1, chg_s2;
    logic [AW-1:0] rd_addr_s1;
    logic [15:0]   beat_cnt, beat_cnt_nxt, byte_len, beat_bytes;
    logic [7:0]    src_q, dst_q;
    logic [63:0]   ts_lat, ts_now;
    logic [31:0]   cyc_cnt, ts_nsec, ts_sec;

    logic accept, in_frame, full_hit, long_hit, last_ok, err_hit, good_last;
    logic data_wr, hdr0_wr, hdr1_wr, rewind;
    logic unused_tuser;

    assign unused_tuser = ^{s_axis.s_axis_tuser[127:97], s_axis.s_axis_tuser[15:0]};

    assign s_axis.s_axis_tready = tready_q;
    assign dbg_state            = state_q;

    // Frame checks: fill has priority over length, both over the tlast verdict.
    assign accept       = s_axis.s_axis_tvalid && tready_q;
    assign in_frame     = (state_q == ST_IDLE) || (state_q == ST_DATA);
    assign beat_cnt_nxt = (state_q == ST_IDLE) ? 16'd1 : beat_cnt + 16'd1;
    assign beat_bytes   = s_axis.s_axis_tlast ? 16'($countones(s_axis.s_axis_tstrb)) : 16'd8;
    assign full_hit     = in_frame && accept && ({1'b0, fill_q} > FILL_LIM);
    assign long_hit     = in_frame && accept && !full_hit && (beat_cnt_nxt > BEATS_LIM);
    assign last_ok      = in_frame && accept && !full_hit && !long_hit && s_axis.s_axis_tlast;
    assign err_hit      = last_ok && s_axis.s_axis_tuser[96];
    assign good_last    = last_ok && !s_axis.s_axis_tuser[96];
    assign ts_now       = (TS_SRC == 0) ? s_axis.s_axis_tuser[95:32] : {ts_sec, ts_nsec};

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (full_hit || long_hit) state_nxt = s_axis.s_axis_tlast ? ST_IDLE : ST_DROP;
                else if (err_hit)         state_nxt = ST_IDLE;
                else if (good_last)       state_nxt = ST_HDR0;
                else if (accept)          state_nxt = ST_DATA;
            end
            ST_HDR0: state_nxt = ST_HDR1;
            ST_HDR1: state_nxt = ST_IDLE;
            ST_DROP: if (accept && s_axis.s_axis_tlast) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        data_wr    = in_frame && accept;
        hdr0_wr    = (state_q == ST_HDR0);
        hdr1_wr    = (state_q == ST_HDR1);
        rewind     = full_hit || long_hit || err_hit;
        tready_nxt = !((state_nxt == ST_HDR0) || (state_nxt == ST_HDR1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tready_q            <= 1'b0;
            aux_ptr             <= AW'(2);
            commited_wr_address <= '0;
            hdr_addr            <= '0;
            fill_q              <= '0;
            wr_addr             <= '0;
            wr_data             <= '0;
            wr_en               <= 1'b0;
            beat_cnt            <= '0;
            byte_len            <= '0;
            src_q               <= '0;
            dst_q               <= '0;
            ts_lat              <= '0;
            dropped_full_cnt    <= '0;
            dropped_err_cnt     <= '0;
            dropped_long_cnt    <= '0;
        end else begin
            tready_q <= tready_nxt;
            wr_en    <= 1'b0;
            fill_q   <= aux_ptr - rd_ptr;

            if (data_wr) begin
                wr_addr  <= aux_ptr;
                wr_data  <= s_axis.s_axis_tdata;
                wr_en    <= 1'b1;
                aux_ptr  <= aux_ptr + AW'(1);
                beat_cnt <= beat_cnt_nxt;
                if (state_q == ST_IDLE) begin
                    byte_len <= beat_bytes;
                    src_q    <= s_axis.s_axis_tuser[23:16];
                    dst_q    <= s_axis.s_axis_tuser[31:24];
                    ts_lat   <= ts_now;
                end else begin
                    byte_len <= byte_len + beat_bytes;
                end
            end

            if (hdr0_wr) begin
                wr_addr             <= commited_wr_address;
                wr_data             <= {16'd0, byte_len, 8'd0, dst_q, 8'd0, src_q};
                wr_en               <= 1'b1;
                hdr_addr            <= commited_wr_address;
                commited_wr_address <= aux_ptr;
                aux_ptr             <= aux_ptr + AW'(1);
            end

            if (hdr1_wr) begin
                wr_addr <= hdr_addr + AW'(1);
                wr_data <= ts_lat;
                wr_en   <= 1'b1;
                aux_ptr <= aux_ptr + AW'(1);
            end

            // Abandoned frames rewind the write pointer past the uncommitted header slots.
            if (rewind) aux_ptr <= commited_wr_address + AW'(2);

            if (full_hit && (dropped_full_cnt != '1)) dropped_full_cnt <= dropped_full_cnt + 32'd1;
            if (long_hit && (dropped_long_cnt != '1)) dropped_long_cnt <= dropped_long_cnt + 32'd1;
            if (err_hit  && (dropped_err_cnt  != '1)) dropped_err_cnt  <= dropped_err_cnt  + 32'd1;
        end
    end

    // Consumer pointer crosses from a foreign domain; the address is trusted once the change flag settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            chg_s1     <= 1'b0;
            chg_s2     <= 1'b0;
            rd_addr_s1 <= '0;
            rd_ptr     <= '0;
        end else begin
            chg_s1     <= commited_rd_address_change;
            chg_s2     <= chg_s1;
            rd_addr_s1 <= commited_rd_address;
            if (chg_s2) rd_ptr <= rd_addr_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            ts_nsec <= '0;
            ts_sec  <= '0;
        end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            ts_nsec <= '0;
            ts_sec  <= ts_sec + 32'd1;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            ts_nsec <= ts_nsec + NS_INC;
        end
    end

endmodule
